// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH) plus borrow-out,
// one bit per clock, LSB first, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic             bit_a, bit_b, d_bit, br_next;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        // Operands are shifted right each bit so the current bit is always at position 0.
        bit_a    = a_q[0];
        bit_b    = b_q[0];
        d_bit    = bit_a ^ bit_b ^ br_q;
        br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                work_d = {d_bit, work_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    diff_d   = {d_bit, work_q[WIDTH-1:1]};
                    borrow_d = br_next;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=4 and WIDTH=8 instances,
// expected results queued at start and compared when done pulses.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4, start8;
    logic [3:0] a4, b4, diff4;
    logic [7:0] a8, b8, diff8;
    logic       busy4, done4, borrow4;
    logic       busy8, done8, borrow8;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       b;
    } exp_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
        logic       br;
    } vec_t;

    exp_t q4[$];
    exp_t q8[$];
    int   total = 0;
    int   passed = 0;
    int   done_cnt4 = 0;
    int   done_cnt8 = 0;
    logic [7:0] last4 = '0;
    logic [7:0] last8 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: each done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            done_cnt4++;
            if (q4.size() == 0) chk("done4_unexpected", 32'd1, 32'd0);
            else begin
                e = q4.pop_front();
                chk("diff4", {28'd0, diff4}, {24'd0, e.d});
                chk("borrow4", {31'd0, borrow4}, {31'd0, e.b});
            end
        end
        if (done8) begin
            done_cnt8++;
            if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
            else begin
                e = q8.pop_front();
                chk("diff8", {24'd0, diff8}, {24'd0, e.d});
                chk("borrow8", {31'd0, borrow8}, {31'd0, e.b});
            end
        end
    end

    function automatic logic get_done(input bit w8);
        return w8 ? done8 : done4;
    endfunction

    function automatic logic get_busy(input bit w8);
        return w8 ? busy8 : busy4;
    endfunction

    function automatic logic [7:0] get_diff(input bit w8);
        return w8 ? diff8 : {4'd0, diff4};
    endfunction

    task automatic drive(input bit w8, input logic s, input logic [7:0] av, input logic [7:0] bv);
        if (w8) begin
            start8 = s; a8 = av; b8 = bv;
        end else begin
            start4 = s; a4 = av[3:0]; b4 = bv[3:0];
        end
    endtask

    // One operation; glitch pulses a second start with swapped operands in the 2nd SHIFT cycle.
    task automatic op(input bit w8, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] exp_d, input logic exp_b, input bit glitch);
        int         w = w8 ? 8 : 4;
        int         n = 0;
        int         busy_n = 0;
        int         dc;
        bit         hold_ok = 1'b1;
        logic [7:0] prev;
        exp_t       e;
        prev = w8 ? last8 : last4;
        dc   = w8 ? done_cnt8 : done_cnt4;
        e.d  = exp_d;
        e.b  = exp_b;
        if (w8) q8.push_back(e);
        else q4.push_back(e);
        drive(w8, 1'b1, av, bv);
        @(negedge clk);
        n = 1;
        while (!get_done(w8) && n < 4 * w) begin
            if (get_busy(w8)) busy_n++;
            if (get_diff(w8) != prev) hold_ok = 1'b0;
            if (glitch && n == 2) drive(w8, 1'b1, bv, av);
            else drive(w8, 1'b0, ~av, ~bv);
            @(negedge clk);
            n++;
        end
        drive(w8, 1'b0, ~av, ~bv);
        chk(w8 ? "latency8" : "latency4", n, w + 1);
        chk(w8 ? "busy_cycles8" : "busy_cycles4", busy_n, w);
        chk(w8 ? "diff_hold8" : "diff_hold4", {31'd0, hold_ok}, 32'd1);
        if (n >= 4 * w) begin
            if (w8) q8.delete();
            else q4.delete();
        end
        @(negedge clk);
        chk(w8 ? "done_count8" : "done_count4", (w8 ? done_cnt8 : done_cnt4) - dc, 1);
        if (w8) last8 = exp_d;
        else last4 = exp_d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[8];
        logic [7:0] ed;
        int         dc;

        vecs[0] = '{a: 4'd9,  b: 4'd3,  d: 4'h6, br: 1'b0};
        vecs[1] = '{a: 4'd3,  b: 4'd9,  d: 4'hA, br: 1'b1};
        vecs[2] = '{a: 4'd0,  b: 4'd1,  d: 4'hF, br: 1'b1};
        vecs[3] = '{a: 4'd0,  b: 4'd0,  d: 4'h0, br: 1'b0};
        vecs[4] = '{a: 4'd15, b: 4'd15, d: 4'h0, br: 1'b0};
        vecs[5] = '{a: 4'd15, b: 4'd0,  d: 4'hF, br: 1'b0};
        vecs[6] = '{a: 4'd0,  b: 4'd15, d: 4'h1, br: 1'b1};
        vecs[7] = '{a: 4'd8,  b: 4'd7,  d: 4'h1, br: 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 8'd0, 8'd0);
        repeat (2) @(negedge clk);
        chk("rst_busy4", {31'd0, busy4}, 32'd0);
        chk("rst_done4", {31'd0, done4}, 32'd0);
        chk("rst_diff4", {28'd0, diff4}, 32'd0);
        chk("rst_borrow4", {31'd0, borrow4}, 32'd0);
        chk("rst_busy8", {31'd0, busy8}, 32'd0);
        chk("rst_diff8", {24'd0, diff8}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            op(1'b0, {4'd0, vecs[i].a}, {4'd0, vecs[i].b}, {4'd0, vecs[i].d}, vecs[i].br, 1'b0);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                ed = 8'((i - j) & 15);
                op(1'b0, 8'(i), 8'(j), ed, i < j, 1'b0);
            end
        end

        // Start during SHIFT must be ignored; result follows the first operands.
        op(1'b0, 8'd12, 8'd5, 8'd7, 1'b0, 1'b1);
        op(1'b0, 8'd2, 8'd11, 8'd7, 1'b1, 1'b1);

        // Reset after two processed bits abandons the operation.
        dc = done_cnt4;
        drive(1'b0, 1'b1, 8'd9, 8'd3);
        repeat (3) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 8'd9, 8'd3);
        end
        chk("pre_reset_busy4", {31'd0, busy4}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy4", {31'd0, busy4}, 32'd0);
        chk("midrst_diff4", {28'd0, diff4}, 32'd0);
        chk("midrst_borrow4", {31'd0, borrow4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("midrst_no_done4", done_cnt4 - dc, 0);
        last4 = '0;
        last8 = '0;
        op(1'b0, 8'd7, 8'd2, 8'd5, 1'b0, 1'b0);

        // WIDTH=8: wrap-around, then diff must hold 8'hFF through the next SHIFT.
        op(1'b1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        op(1'b1, 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
        op(1'b1, 8'h80, 8'hC1, 8'hBF, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
